// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on request and result sides.
// Define ALU_MC_MUL_EN to add a 32-cycle shift-add multiplier on code 1001.
module alu_mc (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  alu_ctrl,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        zero,
   output logic        illegal
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b1000;
`ifdef ALU_MC_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1001;
`endif

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t      state_q;
   logic        in_ready_q;
   logic        out_valid_q;
   logic [31:0] result_q;
   logic        zero_q;
   logic        illegal_q;

   logic        accept;
   logic [31:0] result_d;
   logic        illegal_d;

`ifdef ALU_MC_MUL_EN
   logic        is_mul;
   logic [31:0] mcand_q;
   logic [31:0] mplier_q;
   logic [31:0] acc_q;
   logic [4:0]  iter_q;
   logic [31:0] acc_d;

   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
`endif

   assign accept = in_valid && in_ready_q;

   // Single-cycle operations are evaluated straight from the request so the
   // registered result is already the value captured at accept.
   always_comb begin
      result_d  = 32'd0;
      illegal_d = 1'b0;
`ifdef ALU_MC_MUL_EN
      is_mul    = 1'b0;
`endif
      case (alu_ctrl)
         OP_AND:  result_d = src_a & src_b;
         OP_OR:   result_d = src_a | src_b;
         OP_ADD:  result_d = src_a + src_b;
         OP_SUB:  result_d = src_a - src_b;
         OP_SLT:  result_d = {31'd0, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_MC_MUL_EN
         OP_MUL:  is_mul = 1'b1;
`endif
         default: illegal_d = 1'b1;
      endcase
   end

   // Control FSM; every output is a register so nothing glitches downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= 32'd0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
`ifdef ALU_MC_MUL_EN
         mcand_q     <= 32'd0;
         mplier_q    <= 32'd0;
         acc_q       <= 32'd0;
         iter_q      <= 5'd0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  in_ready_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
                  if (is_mul) begin
                     state_q  <= EXEC;
                     mcand_q  <= src_a;
                     mplier_q <= src_b;
                     acc_q    <= 32'd0;
                     iter_q   <= 5'd0;
                  end else begin
`else
                  begin
`endif
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= result_d;
                     zero_q      <= (result_d == 32'd0);
                     illegal_q   <= illegal_d;
                  end
               end
            end
`ifdef ALU_MC_MUL_EN
            EXEC: begin
               // One multiplier bit per cycle; the product wraps at 32 bits.
               if (flush) begin
                  state_q    <= IDLE;
                  in_ready_q <= 1'b1;
               end else begin
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  acc_q    <= acc_d;
                  iter_q   <= iter_q + 5'd1;
                  if (iter_q == 5'd31) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= acc_d;
                     zero_q      <= (acc_d == 32'd0);
                     illegal_q   <= 1'b0;
                  end
               end
            end
`endif
            DONE: begin
               // A flush coinciding with the handshake still leaves via IDLE.
               if (flush || out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc against an arithmetic reference model.
// Exercises the multiplier only when ALU_MC_MUL_EN is defined.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [3:0]  aluCtrl;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        flush;
   logic        outValid;
   logic        outReady;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   alu_mc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .alu_ctrl  (aluCtrl),
      .src_a     (srcA),
      .src_b     (srcB),
      .flush     (flush),
      .out_valid (outValid),
      .out_ready (outReady),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Reference behaviour: plain arithmetic on the opcode, plus the expected latency.
   function automatic void refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic ill, output int lat);
      logic [63:0] prod;
      res = 32'd0;
      ill = 1'b0;
      lat = 1;
      prod = 64'd0;
      case (op)
         4'd0: res = a & b;
         4'd1: res = a | b;
         4'd2: res = a + b;
         4'd6: res = a - b;
         4'd8: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_MC_MUL_EN
         4'd9: begin
            prod = 64'(a) * 64'(b);
            res  = prod[31:0];
            lat  = 33;
         end
`endif
         default: ill = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // One complete transaction: accept, latency, hold under back-pressure, handshake.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
      logic [31:0] expRes;
      logic        expIll;
      int          expLat;
      int          waitCnt;
      int          lat;
      logic        readyLeak;
      refModel(op, a, b, expRes, expIll, expLat);
      waitCnt = 0;
      while (!inReady && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      if (!inReady) begin
         checkOutput("in_ready_timeout", 32'(inReady), 32'd1);
         return;
      end
      inValid = 1'b1;
      aluCtrl = op;
      srcA    = a;
      srcB    = b;
      @(negedge clk);
      inValid = 1'b0;
      aluCtrl = 4'($urandom);
      srcA    = $urandom;
      srcB    = $urandom;
      lat = 1;
      readyLeak = 1'b0;
      while (!outValid && lat < 100) begin
         if (inReady) readyLeak = 1'b1;
         @(negedge clk);
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'(expLat));
      checkOutput("in_ready_busy", 32'(readyLeak), 32'd0);
      if (!outValid) return;
      repeat (stall) begin
         checkOutput("hold_result", result, expRes);
         checkOutput("hold_illegal", 32'(illegal), 32'(expIll));
         checkOutput("hold_in_ready", 32'(inReady), 32'd0);
         @(negedge clk);
         checkOutput("hold_out_valid", 32'(outValid), 32'd1);
      end
      outReady = 1'b1;
      checkOutput("result", result, expRes);
      checkOutput("zero", 32'(zero), 32'(expRes == 32'd0));
      checkOutput("illegal", 32'(illegal), 32'(expIll));
      @(negedge clk);
      outReady = 1'b0;
      checkOutput("out_valid_drop", 32'(outValid), 32'd0);
      checkOutput("in_ready_after", 32'(inReady), 32'd1);
   endtask

   task automatic watchNoValid(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (outValid) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      logic [3:0] opTable [0:7];
      logic [3:0] op;
      opTable[0] = 4'd0; opTable[1] = 4'd1; opTable[2] = 4'd2; opTable[3] = 4'd6;
      opTable[4] = 4'd8; opTable[5] = 4'd9; opTable[6] = 4'd3; opTable[7] = 4'd15;

      rst = 1'b1; inValid = 1'b0; aluCtrl = 4'd0; srcA = 32'd0; srcB = 32'd0;
      flush = 1'b0; outReady = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_zero", 32'(zero), 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_in_ready", 32'(inReady), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_release_ready", 32'(inReady), 32'd1);

      $display("[TB] directed cases");
      applyStimulus(4'd2, 32'h7FFF_FFFF, 32'd1, 0);
      applyStimulus(4'd6, 32'd5, 32'd5, 1);
      applyStimulus(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
      applyStimulus(4'd8, 32'd1, 32'hFFFF_FFFF, 0);
      applyStimulus(4'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5);
      applyStimulus(4'd9, 32'h0001_0000, 32'h0001_0003, 2);

      // Flush while in DONE drops the result.
      inValid = 1'b1; aluCtrl = 4'd2; srcA = 32'd10; srcB = 32'd20;
      @(negedge clk);
      inValid = 1'b0;
      checkOutput("flush_pre_valid", 32'(outValid), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("flush_done_valid", 32'(outValid), 32'd0);
      checkOutput("flush_done_ready", 32'(inReady), 32'd1);

      // Flush together with the handshake.
      inValid = 1'b1; aluCtrl = 4'd1; srcA = 32'hF0; srcB = 32'h0F;
      @(negedge clk);
      inValid = 1'b0;
      checkOutput("flush_hs_result", result, 32'hFF);
      flush = 1'b1; outReady = 1'b1;
      @(negedge clk);
      flush = 1'b0; outReady = 1'b0;
      checkOutput("flush_hs_valid", 32'(outValid), 32'd0);
      checkOutput("flush_hs_ready", 32'(inReady), 32'd1);

      // Flush in IDLE is ignored, the concurrent request is still accepted.
      inValid = 1'b1; flush = 1'b1; aluCtrl = 4'd2; srcA = 32'd7; srcB = 32'd8;
      @(negedge clk);
      inValid = 1'b0; flush = 1'b0;
      checkOutput("flush_idle_valid", 32'(outValid), 32'd1);
      checkOutput("flush_idle_result", result, 32'd15);
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;

`ifdef ALU_MC_MUL_EN
      inValid = 1'b1; aluCtrl = 4'd9; srcA = 32'h1234; srcB = 32'h5678;
      @(negedge clk);
      inValid = 1'b0;
      repeat (9) @(negedge clk);
      checkOutput("mul_flush_busy", 32'(inReady), 32'd0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("mul_flush_idle", 32'(inReady), 32'd1);
      checkOutput("mul_flush_valid", 32'(outValid), 32'd0);
      watchNoValid("mul_flush_stale", 40);
      applyStimulus(4'd2, 32'd2, 32'd3, 0);
`endif

      // Reset pulsed while an operation is in flight.
`ifdef ALU_MC_MUL_EN
      inValid = 1'b1; aluCtrl = 4'd9; srcA = 32'd3; srcB = 32'd4;
      @(negedge clk);
      inValid = 1'b0;
      repeat (5) @(negedge clk);
`else
      inValid = 1'b1; aluCtrl = 4'd2; srcA = 32'd1; srcB = 32'd1;
      @(negedge clk);
      inValid = 1'b0;
`endif
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
      checkOutput("midrst_result", result, 32'd0);
      checkOutput("midrst_zero", 32'(zero), 32'd0);
      checkOutput("midrst_illegal", 32'(illegal), 32'd0);
      checkOutput("midrst_in_ready", 32'(inReady), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_release_ready", 32'(inReady), 32'd1);
      watchNoValid("midrst_stale", 40);
      applyStimulus(4'd2, 32'd2, 32'd3, 0);

      $display("[TB] random cases");
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) < 8) op = opTable[$urandom_range(0, 7)];
         else op = 4'($urandom);
         applyStimulus(op, pickOperand(), pickOperand(), int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
